// File: rtl/uart_tx.sv
// 8N1 UART transmitter fed by a small circular FIFO.
// The byte-side handshake (data/data_val/ready) mirrors the receiver's output so the two can be chained.
module uart_tx #(
    parameter int CLK_RATE   = 8125,
    parameter int BAUD_RATE  = 1200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       areset_n,
    input  logic [7:0] data,
    input  logic       data_val,
    output logic       ready,
    output logic       tx,
    output logic       busy
);

    localparam int CLKS_PER_BAUD = CLK_RATE / BAUD_RATE;
    localparam int PTR_W         = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W         = $clog2(FIFO_DEPTH + 1);
    localparam int BAUD_W        = (CLKS_PER_BAUD > 1) ? $clog2(CLKS_PER_BAUD) : 1;

    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BAUD - 1);

    generate
        if (CLKS_PER_BAUD < 2) begin : g_bad_baud
            $error("uart_tx: CLK_RATE / BAUD_RATE must be at least 2");
        end
        if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("uart_tx: FIFO_DEPTH must be a power of two and at least 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic [7:0]          r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]    r_count;

    logic [7:0]          r_shift;
    logic [BAUD_W-1:0]   r_baud_cnt;
    logic [2:0]          r_bit_cnt;
    logic                r_tx;

    logic                w_push;
    logic                w_pop;
    logic                w_fifo_empty;
    logic                w_baud_end;
    logic                w_baud_restart;
    logic                w_shift_right;
    logic                w_bit_clr;
    logic                w_bit_inc;
    logic                w_tx_next;

    assign ready          = (r_count != FULL_CNT);
    assign busy           = (r_state != S_IDLE) || (r_count != '0);
    assign tx             = r_tx;

    assign w_fifo_empty   = (r_count == '0);
    assign w_push         = data_val && ready;
    assign w_baud_end     = (r_baud_cnt == BAUD_LAST);
    assign w_baud_restart = (r_state == S_IDLE) || w_baud_end;

    // Storage has no reset: entries are only ever read after being written.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data;
        end
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A pop from STOP starts the next start bit on the same edge, so queued frames abut.
    always_comb begin
        w_state_next  = r_state;
        w_pop         = 1'b0;
        w_shift_right = 1'b0;
        w_bit_clr     = 1'b0;
        w_bit_inc     = 1'b0;
        w_tx_next     = r_tx;
        case (r_state)
            S_IDLE: begin
                w_tx_next = 1'b1;
                if (!w_fifo_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = S_START;
                    w_tx_next    = 1'b0;
                end
            end
            S_START: begin
                if (w_baud_end) begin
                    w_state_next = S_DATA;
                    w_bit_clr    = 1'b1;
                    w_tx_next    = r_shift[0];
                end
            end
            S_DATA: begin
                if (w_baud_end) begin
                    if (r_bit_cnt == 3'd7) begin
                        w_state_next = S_STOP;
                        w_tx_next    = 1'b1;
                    end else begin
                        w_shift_right = 1'b1;
                        w_bit_inc     = 1'b1;
                        w_tx_next     = r_shift[1];
                    end
                end
            end
            S_STOP: begin
                if (w_baud_end) begin
                    if (!w_fifo_empty) begin
                        w_pop        = 1'b1;
                        w_state_next = S_START;
                        w_tx_next    = 1'b0;
                    end else begin
                        w_state_next = S_IDLE;
                        w_tx_next    = 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_tx_next    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            r_shift    <= '0;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_tx       <= 1'b1;
        end else begin
            r_tx <= w_tx_next;
            if (w_pop) begin
                r_shift <= r_mem[r_rd_ptr];
            end else if (w_shift_right) begin
                r_shift <= {1'b0, r_shift[7:1]};
            end
            if (w_baud_restart) begin
                r_baud_cnt <= '0;
            end else begin
                r_baud_cnt <= r_baud_cnt + 1'b1;
            end
            if (w_bit_clr) begin
                r_bit_cnt <= '0;
            end else if (w_bit_inc) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx: table-driven single-frame vectors plus hand-written FIFO, loopback and reset sequences.
// A behavioural 8N1 receiver decodes the line independently of the design.
module tb_uart_tx;

    localparam int CPB = 6;

    logic       clk      = 1'b0;
    logic       areset_n = 1'b0;
    logic [7:0] data     = 8'h00;
    logic       data_val = 1'b0;
    logic       ready;
    logic       tx;
    logic       busy;

    int         errors     = 0;
    int         checks     = 0;
    int         cycleCount = 0;
    int         rxFrameErr = 0;
    int         acceptLog[$];
    logic [7:0] rxQ[$];

    typedef struct {
        logic [7:0] value;
        logic [9:0] levels;
    } vec_t;

    vec_t vecs[5];

    uart_tx #(
        .CLK_RATE   (8125),
        .BAUD_RATE  (1200),
        .FIFO_DEPTH (4)
    ) dut (
        .clk      (clk),
        .areset_n (areset_n),
        .data     (data),
        .data_val (data_val),
        .ready    (ready),
        .tx       (tx),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (areset_n && data_val && ready) begin
            acceptLog.push_back(cycleCount);
        end
        cycleCount <= cycleCount + 1;
    end

    // Receiver samples each bit in its middle (fourth of six clocks), starting from the first low sample.
    initial begin : rxModel
        logic [7:0] sh;
        sh = 8'h00;
        forever begin
            @(negedge clk);
            if (areset_n && tx === 1'b0) begin
                repeat (3) @(negedge clk);
                if (tx !== 1'b0) begin
                    rxFrameErr++;
                end else begin
                    for (int b = 0; b < 8; b++) begin
                        repeat (CPB) @(negedge clk);
                        sh[b] = tx;
                    end
                    repeat (CPB) @(negedge clk);
                    if (tx !== 1'b1) begin
                        rxFrameErr++;
                    end
                    rxQ.push_back(sh);
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    // Called right after a negedge; returns right after the negedge following acceptance.
    task automatic pushByte(input logic [7:0] b);
        int guard;
        guard    = 0;
        data     = b;
        data_val = 1'b1;
        while (ready !== 1'b1 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        checkOutput($sformatf("push 0x%02h ready", b), 32'(ready), 1);
        @(negedge clk);
        data_val = 1'b0;
    endtask

    task automatic waitIdle(input string name);
        int guard;
        guard = 0;
        while (busy !== 1'b0 && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        checkOutput({name, " idle"}, 32'(busy), 0);
    endtask

    task automatic checkRx(input string name, input logic [7:0] expBytes[$]);
        checkOutput({name, " rx count"}, rxQ.size(), expBytes.size());
        for (int i = 0; i < expBytes.size() && i < rxQ.size(); i++) begin
            checkOutput($sformatf("%s rx byte %0d", name, i), 32'(rxQ[i]), 32'(expBytes[i]));
        end
        checkOutput({name, " framing"}, rxFrameErr, 0);
    endtask

    // One byte into an idle transmitter: tx low one edge after the push, ten 6-clock levels, busy drops at k+61.
    task automatic applyStimulus(input vec_t v);
        logic seen;
        logic [7:0] expOne[$];
        rxQ.delete();
        rxFrameErr = 0;
        data     = v.value;
        data_val = 1'b1;
        @(negedge clk);
        data_val = 1'b0;
        checkOutput($sformatf("frame %02h tx before pop", v.value), 32'(tx), 1);
        checkOutput($sformatf("frame %02h busy after push", v.value), 32'(busy), 1);
        for (int p = 0; p < 10; p++) begin
            seen = v.levels[p];
            for (int s = 0; s < CPB; s++) begin
                @(negedge clk);
                if (tx !== v.levels[p]) begin
                    seen = tx;
                end
            end
            checkOutput($sformatf("frame %02h period %0d", v.value, p), 32'(seen), 32'(v.levels[p]));
        end
        checkOutput($sformatf("frame %02h busy at k+60", v.value), 32'(busy), 1);
        @(negedge clk);
        checkOutput($sformatf("frame %02h busy at k+61", v.value), 32'(busy), 0);
        checkOutput($sformatf("frame %02h tx idle", v.value), 32'(tx), 1);
        expOne.push_back(v.value);
        checkRx($sformatf("frame %02h", v.value), expOne);
    endtask

    initial begin : main
        int k;
        int fallEdge;
        int guard;
        int stayHigh;
        int stayIdle;
        logic [7:0] expQ[$];

        // Levels per bit period: [0] start, [1..8] data LSB first, [9] stop.
        vecs[0] = '{value: 8'h68, levels: 10'b1011010000};
        vecs[1] = '{value: 8'h00, levels: 10'b1000000000};
        vecs[2] = '{value: 8'hFF, levels: 10'b1111111110};
        vecs[3] = '{value: 8'h55, levels: 10'b1010101010};
        vecs[4] = '{value: 8'h81, levels: 10'b1100000010};

        $display("[TB] reset state");
        repeat (3) @(negedge clk);
        checkOutput("reset tx", 32'(tx), 1);
        checkOutput("reset ready", 32'(ready), 1);
        checkOutput("reset busy", 32'(busy), 0);
        areset_n = 1'b1;
        stayHigh = 1;
        repeat (12) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) stayHigh = 0;
        end
        checkOutput("post-reset quiet line", stayHigh, 1);

        $display("[TB] single-frame vectors");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i]);
            repeat (3) @(negedge clk);
        end

        $display("[TB] loopback");
        rxQ.delete();
        rxFrameErr = 0;
        expQ = '{8'h68, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h0A, 8'h55};
        foreach (expQ[i]) pushByte(expQ[i]);
        waitIdle("loopback");
        @(negedge clk);
        checkRx("loopback", expQ);

        $display("[TB] fifo full back-to-back");
        rxQ.delete();
        rxFrameErr = 0;
        acceptLog.delete();
        @(negedge clk);
        k = cycleCount;
        for (int b = 1; b <= 6; b++) pushByte(8'(b));
        checkOutput("full accept count", acceptLog.size(), 6);
        for (int i = 0; i < 5 && i < acceptLog.size(); i++) begin
            checkOutput($sformatf("full accept %0d edge", i), acceptLog[i] - k, i);
        end
        if (acceptLog.size() > 5) begin
            checkOutput("full sixth accept edge", acceptLog[5] - k, 62);
        end
        guard = 0;
        while (busy !== 1'b0 && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        fallEdge = cycleCount - 1;
        checkOutput("full busy fall edge", fallEdge - k, 361);
        expQ = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        checkRx("full", expQ);

        $display("[TB] ignored push");
        repeat (3) @(negedge clk);
        rxQ.delete();
        rxFrameErr = 0;
        acceptLog.delete();
        expQ = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h99};
        foreach (expQ[i]) pushByte(expQ[i]);
        checkOutput("ignored ready low", 32'(ready), 0);
        data     = 8'hAA;
        data_val = 1'b1;
        @(negedge clk);
        data_val = 1'b0;
        checkOutput("ignored accept count", acceptLog.size(), 5);
        waitIdle("ignored");
        @(negedge clk);
        checkRx("ignored", expQ);

        $display("[TB] reset mid-frame");
        repeat (3) @(negedge clk);
        rxQ.delete();
        rxFrameErr = 0;
        pushByte(8'h55);
        pushByte(8'h33);
        repeat (26) @(negedge clk);
        checkOutput("midframe bit3 level", 32'(tx), 0);
        #2;
        areset_n = 1'b0;
        #1;
        checkOutput("midframe reset tx", 32'(tx), 1);
        checkOutput("midframe reset ready", 32'(ready), 1);
        checkOutput("midframe reset busy", 32'(busy), 0);
        @(negedge clk);
        areset_n = 1'b1;
        repeat (150) @(negedge clk);
        rxQ.delete();
        rxFrameErr = 0;
        stayHigh = 1;
        stayIdle = 1;
        repeat (200) begin
            @(negedge clk);
            if (tx !== 1'b1) stayHigh = 0;
            if (busy !== 1'b0) stayIdle = 0;
        end
        checkOutput("after reset line high", stayHigh, 1);
        checkOutput("after reset not busy", stayIdle, 1);
        checkOutput("after reset no frame", rxQ.size(), 0);
        pushByte(8'h3C);
        waitIdle("after reset");
        @(negedge clk);
        expQ = '{8'h3C};
        checkRx("after reset", expQ);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter with a small input FIFO. It serialises bytes as 8N1 frames (one start bit, 8 data bits LSB first, one stop bit) on a single line at a fixed baud rate derived from the system clock. It is the transmit-side counterpart of the UART receiver. Its byte-side handshake (`data`/`data_val`/`ready`) matches the receiver's output, so a receiver's output can drive it directly for echo and loopback.

## Interface
- `CLK_RATE`, default 8125: system clock frequency in Hz.
- `BAUD_RATE`, default 1200: line rate in bit/s.
- `FIFO_DEPTH`, default 4: transmit FIFO entries; power of two, ≥2.
- Derived: `CLKS_PER_BAUD = CLK_RATE / BAUD_RATE` (integer, truncating); must be ≥2, enforced by elaboration-time check.
- `clk`  in  1  system clock; all logic on the rising edge.
- `areset_n`  in  1  reset, asynchronous, active-low.
- `data`  in  8  byte to transmit.
- `data_val`  in  1  `data` is valid.
- `ready`  out  1  FIFO can accept a byte.
- `tx`  out  1  serial line, idle high, registered.
- `busy`  out  1  FIFO non-empty or a frame in progress.

## Operation
- Handshake: a byte is pushed at a rising edge where `data_val && ready`. If `data_val` is high while `ready` is low, the byte is ignored; there is no error flag.
- `ready = (count != FIFO_DEPTH)`, decoded from registered state only. There is no combinational path from `data_val`.
- FIFO: circular buffer with read/write pointers and a count.
  - A simultaneous push and pop leaves the count unchanged; both are honoured.
  - Pointers wrap modulo `FIFO_DEPTH`.
- FSM states: IDLE, START, DATA, STOP.
  - **IDLE**: `tx`=1. If the FIFO is non-empty: pop the head into the shift register, clear the baud counter, go to START, `tx`←0.
  - **START**: hold `tx`=0 for `CLKS_PER_BAUD` cycles. Then go to DATA with `bit_cnt`=0, and `tx`←shift[0].
  - **DATA**: each bit is held `CLKS_PER_BAUD` cycles, then the register shifts right. After bit 7 go to STOP, `tx`←1.
  - **STOP**: hold `tx`=1 for `CLKS_PER_BAUD` cycles. At the end:
    - FIFO non-empty: pop and go directly to START (no idle gap).
    - Otherwise: go to IDLE.
- Baud counter runs 0..`CLKS_PER_BAUD`-1 and restarts at every bit boundary. `bit_cnt` is 3 bits.
- `busy = (state != IDLE) || (count != 0)`.
- Reset values:
  - `tx`=1, `ready`=1, `busy`=0.
  - FIFO empty, state IDLE, all counters 0.
- Reset mid-frame: the frame is abandoned. `tx` returns to 1 asynchronously and the FIFO contents are discarded. No partial frame resumes after release.

## Timing
- Byte pushed at edge k into an empty FIFO while in IDLE: the pop occurs at edge k+1, and `tx` is low from edge k+1.
- Each bit occupies exactly `CLKS_PER_BAUD` clocks. A frame occupies exactly 10·`CLKS_PER_BAUD` clocks.
- Back-to-back frames: the next start bit begins on the edge that ends the previous stop bit. N queued bytes take exactly 10·N·`CLKS_PER_BAUD` clocks.
- When a pop frees a slot in a full FIFO, `ready` rises in the cycle after the popping edge.
- `busy` falls at the edge that ends the last stop bit with the FIFO empty.
- Default parameters give `CLKS_PER_BAUD`=6 and a frame of 60 clocks.

## Test plan
- **Reset**: assert `areset_n`=0 at an arbitrary time with no clock edge.
  - Outputs go immediately to `tx`=1, `ready`=1, `busy`=0.
  - `tx` stays 1 after release with no input.
- **Single byte**: push 0x68 at edge k (default params).
  - `tx` is low from edge k+1.
  - Then each of the following levels is held 6 clocks: 0,0,0,1,0,1,1,0, then 1.
  - `busy` falls at edge k+61.
- **Loopback**: `tx` feeds a UART receiver instance with the same `CLK_RATE`/`BAUD_RATE`, receiver `ready`=1.
  - Push 0x68,0x65,0x6C,0x6C,0x6F,0x0A,0x55, honouring `ready`.
  - The receiver emits exactly those 7 bytes in order, with no baud error.
- **FIFO full / back-to-back**: hold `data_val`=1 from edge k with bytes 0x01..0x06 (`FIFO_DEPTH`=4).
  - Exactly 5 bytes are accepted, at edges k..k+4; `ready` is low from k+5.
  - 0x06 is accepted only after `ready` rises again.
  - The total line activity is 360 clocks with no idle-high gaps between frames.
- **Ignored push**: with the FIFO full, pulse `data_val` with 0xAA while `ready`=0.
  - 0xAA never appears on `tx`.
  - The queued bytes are sent unchanged.
- **Reset mid-frame**: assert reset during DATA bit 3 of 0x55 with a second byte queued.
  - `tx`=1 immediately.
  - After release, no frame is transmitted until a new push.
